// File: rtl/config_seq_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// config_seq_pkg : shared types and constants for the config sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package config_seq_pkg;

    localparam int                C_NO_CFG_BITS = 24;
    localparam logic [23:0]       DEFAULT_CFG   = 24'hAEC9EC;
    localparam int                FAIL_CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_END = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAIL     = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/config_seq_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// config_seq_ctrl_if : decoder / host / CONFIG_TX signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface config_seq_ctrl_if
    import config_seq_pkg::*;
#(
    parameter int W = C_NO_CFG_BITS
);
    logic                  CONFIG_EN;
    logic                  TX_END;
    logic [W-1:0]          HOST_CFG;
    logic                  HOST_CFG_VALID;
    logic                  HOST_CFG_READY;
    logic                  ERR_CLR;
    logic                  TX_START;
    logic [W-1:0]          TX_WORD;
    logic                  CONFIG_DONE;
    logic                  BUSY;
    logic                  CFG_ERROR;
    logic [W-1:0]          ACTIVE_CFG;
    logic [FAIL_CNT_W-1:0] FAIL_CNT;

    modport master (
        output CONFIG_EN, TX_END, HOST_CFG, HOST_CFG_VALID, ERR_CLR,
        input  HOST_CFG_READY, TX_START, TX_WORD, CONFIG_DONE, BUSY,
               CFG_ERROR, ACTIVE_CFG, FAIL_CNT
    );

    modport slave (
        input  CONFIG_EN, TX_END, HOST_CFG, HOST_CFG_VALID, ERR_CLR,
        output HOST_CFG_READY, TX_START, TX_WORD, CONFIG_DONE, BUSY,
               CFG_ERROR, ACTIVE_CFG, FAIL_CNT
    );
endinterface
`default_nettype wire

// File: rtl/config_seq_ctrl_timeout_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfg_timeout_cnt : clear/enable cycle counter, flags TIMEOUT_CYCLES-1
// Rev 1.0
// ---------------------------------------------------------------------------
module cfg_timeout_cnt
    import config_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expired_o
);
    localparam int            CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == C_LAST);
endmodule
`default_nettype wire

// File: rtl/config_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// config_seq_ctrl : launches one CONFIG_TX transfer per config window with
//                   timeout/retry supervision and a one-deep host word slot
// Rev 1.0
// ---------------------------------------------------------------------------
module config_seq_ctrl #(
    parameter int                                  C_NO_CFG_BITS  = config_seq_pkg::C_NO_CFG_BITS,
    parameter logic [C_NO_CFG_BITS-1:0]            DEFAULT_CFG    = config_seq_pkg::DEFAULT_CFG,
    parameter int                                  TIMEOUT_CYCLES = 4096,
    parameter int                                  MAX_RETRY      = 2
) (
    input  wire logic        CLOCK,
    input  wire logic        RESET,
    config_seq_ctrl_if.slave bus
);
    import config_seq_pkg::*;

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_LOAD     = ST_LOAD;
    localparam logic [2:0] S_START    = ST_START;
    localparam logic [2:0] S_WAIT_END = ST_WAIT_END;
    localparam logic [2:0] S_DONE     = ST_DONE;
    localparam logic [2:0] S_FAIL     = ST_FAIL;

    localparam int            RW           = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] C_RETRY_LAST = RW'(MAX_RETRY);

    logic [2:0]               state_q, state_d;
    logic                     en_q;
    logic                     pend_q;
    logic [C_NO_CFG_BITS-1:0] pend_word_q;
    logic                     sent_host_q;
    logic [RW-1:0]            retry_q;
    logic [C_NO_CFG_BITS-1:0] tx_word_q;
    logic [C_NO_CFG_BITS-1:0] active_q;
    logic                     err_q;
    logic [FAIL_CNT_W-1:0]    fail_cnt_q;

    logic w_en_rise;
    logic w_expired;
    logic w_retry_ok;

    assign w_en_rise  = bus.CONFIG_EN & ~en_q;
    assign w_retry_ok = (retry_q < C_RETRY_LAST);

    cfg_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (CLOCK),
        .rst       (RESET),
        .clr_i     (state_q == S_START),
        .en_i      (state_q == S_WAIT_END),
        .expired_o (w_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (w_en_rise) state_d = S_LOAD;
            S_LOAD:     state_d = S_START;
            S_START:    state_d = S_WAIT_END;
            S_WAIT_END: begin
                // A completion in the expiry cycle still counts as success.
                if (bus.TX_END)      state_d = S_DONE;
                else if (w_expired)  state_d = w_retry_ok ? S_START : S_FAIL;
            end
            S_DONE:     state_d = S_IDLE;
            S_FAIL:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            sent_host_q <= 1'b0;
            retry_q     <= '0;
            tx_word_q   <= DEFAULT_CFG;
            active_q    <= DEFAULT_CFG;
            err_q       <= 1'b0;
            fail_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= bus.CONFIG_EN;

            if (bus.HOST_CFG_VALID && !pend_q) begin
                pend_q      <= 1'b1;
                pend_word_q <= bus.HOST_CFG;
            end else if (state_q == S_DONE && sent_host_q) begin
                pend_q <= 1'b0;
            end

            if (state_q == S_LOAD) begin
                tx_word_q   <= pend_q ? pend_word_q : active_q;
                sent_host_q <= pend_q;
                retry_q     <= '0;
            end

            if (state_q == S_WAIT_END && !bus.TX_END && w_expired && w_retry_ok) begin
                retry_q <= retry_q + 1'b1;
            end

            if (state_q == S_WAIT_END && bus.TX_END) begin
                active_q <= tx_word_q;
            end

            // Setting the error in the FAIL cycle overrides a coincident clear.
            if (state_q == S_FAIL) begin
                err_q <= 1'b1;
                if (fail_cnt_q != {FAIL_CNT_W{1'b1}}) begin
                    fail_cnt_q <= fail_cnt_q + 1'b1;
                end
            end else if (bus.ERR_CLR) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.HOST_CFG_READY = ~pend_q;
    assign bus.TX_START       = (state_q == S_START);
    assign bus.TX_WORD        = tx_word_q;
    assign bus.CONFIG_DONE    = (state_q == S_DONE) || (state_q == S_FAIL);
    assign bus.BUSY           = (state_q != S_IDLE);
    assign bus.CFG_ERROR      = err_q;
    assign bus.ACTIVE_CFG     = active_q;
    assign bus.FAIL_CNT       = fail_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_config_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_config_seq_ctrl : directed vector bench for config_seq_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_config_seq_ctrl;
    localparam int TO    = 512;
    localparam int RETRY = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    config_seq_ctrl_if #(.W(24)) bus ();

    config_seq_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRY      (RETRY)
    ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct {
        bit          host_wr;
        logic [23:0] host_word;
        int          end_dly;     // edges from TX_START to TX_END sample; 0 = never
        bit          clr_hold;
        logic [23:0] exp_word;
        logic [23:0] exp_active;
        bit          exp_err;
        logic [7:0]  exp_fcnt;
        bit          exp_ready;
        bit          ready_at_done;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_window(input vec_t v);
        if (v.host_wr) begin
            bus.HOST_CFG       = v.host_word;
            bus.HOST_CFG_VALID = 1'b1;
            chk("ready_before_write", 32'(bus.HOST_CFG_READY), 32'd1);
            tick();
            bus.HOST_CFG_VALID = 1'b0;
            chk("ready_after_write", 32'(bus.HOST_CFG_READY), 32'd0);
        end
        bus.ERR_CLR   = v.clr_hold;
        bus.CONFIG_EN = 1'b1;
        tick();
        chk("busy_in_load", 32'(bus.BUSY), 32'd1);
        chk("no_start_in_load", 32'(bus.TX_START), 32'd0);
        bus.CONFIG_EN = 1'b0;
        tick();
        chk("tx_start", 32'(bus.TX_START), 32'd1);
        chk("tx_word", 32'(bus.TX_WORD), 32'(v.exp_word));
        if (v.end_dly > 0) begin
            repeat (v.end_dly - 1) tick();
            bus.TX_END = 1'b1;
            tick();
            bus.TX_END = 1'b0;
            chk("done_pulse", 32'(bus.CONFIG_DONE), 32'd1);
            chk("no_retry", 32'(bus.TX_START), 32'd0);
            chk("active_at_done", 32'(bus.ACTIVE_CFG), 32'(v.exp_active));
            chk("ready_at_done", 32'(bus.HOST_CFG_READY), 32'(v.ready_at_done));
        end else begin
            for (int a = 0; a <= RETRY; a++) begin
                repeat (TO) tick();
                chk("quiet_before_expiry", 32'({bus.TX_START, bus.CONFIG_DONE}), 32'd0);
                tick();
                if (a < RETRY) chk("retry_start", 32'(bus.TX_START), 32'd1);
                else           chk("fail_done", 32'(bus.CONFIG_DONE), 32'd1);
            end
        end
        tick();
        bus.ERR_CLR = 1'b0;
        chk("done_one_cycle", 32'(bus.CONFIG_DONE), 32'd0);
        chk("idle_not_busy", 32'(bus.BUSY), 32'd0);
        chk("cfg_error", 32'(bus.CFG_ERROR), 32'(v.exp_err));
        chk("fail_cnt", 32'(bus.FAIL_CNT), 32'(v.exp_fcnt));
        chk("ready_after", 32'(bus.HOST_CFG_READY), 32'(v.exp_ready));
        chk("active_after", 32'(bus.ACTIVE_CFG), 32'(v.exp_active));
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{1'b0, 24'h000000, 461,    1'b0, 24'hAEC9EC, 24'hAEC9EC, 1'b0, 8'd0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 24'h123456, 461,    1'b0, 24'h123456, 24'h123456, 1'b0, 8'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 24'h000000, TO + 1, 1'b0, 24'h123456, 24'h123456, 1'b0, 8'd0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 24'hABCDEF, 0,      1'b1, 24'hABCDEF, 24'h123456, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 24'h000000, 10,     1'b0, 24'hABCDEF, 24'hABCDEF, 1'b1, 8'd1, 1'b1, 1'b0};

        rst                = 1'b1;
        bus.CONFIG_EN      = 1'b0;
        bus.TX_END         = 1'b0;
        bus.HOST_CFG       = '0;
        bus.HOST_CFG_VALID = 1'b0;
        bus.ERR_CLR        = 1'b0;
        repeat (3) tick();
        chk("rst_tx_start", 32'(bus.TX_START), 32'd0);
        chk("rst_done", 32'(bus.CONFIG_DONE), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_err", 32'(bus.CFG_ERROR), 32'd0);
        chk("rst_fcnt", 32'(bus.FAIL_CNT), 32'd0);
        chk("rst_tx_word", 32'(bus.TX_WORD), 32'hAEC9EC);
        chk("rst_active", 32'(bus.ACTIVE_CFG), 32'hAEC9EC);
        chk("rst_ready", 32'(bus.HOST_CFG_READY), 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_window(vecs[i]);

        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        chk("err_clr", 32'(bus.CFG_ERROR), 32'd0);
        chk("fcnt_kept", 32'(bus.FAIL_CNT), 32'd1);

        // Stray TX_END while idle must not produce a completion.
        bus.TX_END = 1'b1;
        tick();
        bus.TX_END = 1'b0;
        chk("stray_end_done", 32'(bus.CONFIG_DONE), 32'd0);
        tick();
        chk("stray_end_busy", 32'(bus.BUSY), 32'd0);

        // Host write during LOAD plus CONFIG_EN re-pulse during WAIT_END.
        bus.CONFIG_EN = 1'b1;
        tick();
        chk("load_busy", 32'(bus.BUSY), 32'd1);
        bus.HOST_CFG       = 24'h55AA33;
        bus.HOST_CFG_VALID = 1'b1;
        tick();
        bus.HOST_CFG_VALID = 1'b0;
        bus.CONFIG_EN      = 1'b0;
        chk("late_word_start", 32'(bus.TX_START), 32'd1);
        chk("late_word_not_used", 32'(bus.TX_WORD), 32'hABCDEF);
        chk("late_word_pending", 32'(bus.HOST_CFG_READY), 32'd0);
        tick();
        bus.CONFIG_EN = 1'b1;
        tick();
        chk("repulse_no_start1", 32'(bus.TX_START), 32'd0);
        bus.CONFIG_EN = 1'b0;
        tick();
        chk("repulse_no_start2", 32'(bus.TX_START), 32'd0);
        bus.TX_END = 1'b1;
        tick();
        bus.TX_END = 1'b0;
        chk("repulse_done", 32'(bus.CONFIG_DONE), 32'd1);
        chk("repulse_no_start3", 32'(bus.TX_START), 32'd0);
        tick();
        chk("late_word_kept", 32'(bus.HOST_CFG_READY), 32'd0);
        tick();
        chk("no_second_launch", 32'(bus.BUSY), 32'd0);
        v = '{1'b0, 24'h000000, 5, 1'b0, 24'h55AA33, 24'h55AA33, 1'b0, 8'd1, 1'b1, 1'b0};
        run_window(v);

        // Reset in WAIT_END drops the pending word and restores reset values.
        bus.HOST_CFG       = 24'h777777;
        bus.HOST_CFG_VALID = 1'b1;
        tick();
        bus.HOST_CFG_VALID = 1'b0;
        bus.CONFIG_EN      = 1'b1;
        tick();
        bus.CONFIG_EN = 1'b0;
        repeat (3) tick();
        chk("pre_reset_busy", 32'(bus.BUSY), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        chk("mid_rst_done", 32'(bus.CONFIG_DONE), 32'd0);
        chk("mid_rst_start", 32'(bus.TX_START), 32'd0);
        chk("mid_rst_fcnt", 32'(bus.FAIL_CNT), 32'd0);
        chk("mid_rst_tx_word", 32'(bus.TX_WORD), 32'hAEC9EC);
        chk("mid_rst_active", 32'(bus.ACTIVE_CFG), 32'hAEC9EC);
        chk("mid_rst_ready", 32'(bus.HOST_CFG_READY), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
